// File: rtl/pq_array_ctrl_if.sv
// Client request/acknowledge, head-cell command/response and status bundle
// shared by pq_array_ctrl and the logic around it.
interface pq_array_ctrl_if #(
  parameter int IW    = 4,
  parameter int PW    = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push_req_i;
  logic [IW-1:0] push_id_i;
  logic [PW-1:0] push_prio_i;
  logic          pop_req_i;
  logic          drop_req_i;
  logic [IW-1:0] drop_id_i;
  logic          push_ack_o;
  logic          pop_ack_o;
  logic          drop_ack_o;
  logic          ok_o;
  logic [IW-1:0] pop_id_o;
  logic [PW-1:0] pop_prio_o;
  logic          arr_push_o;
  logic          arr_pop_o;
  logic          arr_drop_o;
  logic [IW-1:0] arr_id_o;
  logic [PW-1:0] arr_prio_o;
  logic [IW-1:0] arr_drop_id_o;
  logic          arr_push_vld_i;
  logic          arr_pop_vld_i;
  logic          arr_drop_vld_i;
  logic          arr_drop_hit_i;
  logic [IW-1:0] arr_id_i;
  logic [PW-1:0] arr_prio_i;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;
  logic          busy_o;
  logic          err_o;

  modport slave (
    input  push_req_i, push_id_i, push_prio_i, pop_req_i, drop_req_i, drop_id_i,
    input  arr_push_vld_i, arr_pop_vld_i, arr_drop_vld_i, arr_drop_hit_i,
    input  arr_id_i, arr_prio_i,
    output push_ack_o, pop_ack_o, drop_ack_o, ok_o, pop_id_o, pop_prio_o,
    output arr_push_o, arr_pop_o, arr_drop_o, arr_id_o, arr_prio_o, arr_drop_id_o,
    output count_o, full_o, empty_o, busy_o, err_o
  );

  modport master (
    output push_req_i, push_id_i, push_prio_i, pop_req_i, drop_req_i, drop_id_i,
    output arr_push_vld_i, arr_pop_vld_i, arr_drop_vld_i, arr_drop_hit_i,
    output arr_id_i, arr_prio_i,
    input  push_ack_o, pop_ack_o, drop_ack_o, ok_o, pop_id_o, pop_prio_o,
    input  arr_push_o, arr_pop_o, arr_drop_o, arr_id_o, arr_prio_o, arr_drop_id_o,
    input  count_o, full_o, empty_o, busy_o, err_o
  );
endinterface

// File: rtl/pq_array_ctrl.sv
// Front-end sequencer for the systolic priority-queue array: arbitrates client
// push/pop/drop requests and runs one head-cell command at a time.
module pq_array_ctrl #(
  parameter int IW    = 4,
  parameter int PW    = 8,
  parameter int DEPTH = 8,
  parameter int TMO   = 16
) (
  input logic            clk_i,
  input logic            rst_ni,
  pq_array_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_DROP = 2'd3
  } op_e;

  state_e        state_r, state_s;
  op_e           op_r, op_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [CW-1:0] count_r, count_s;
  logic          full_r, full_s;
  logic          empty_r, empty_s;
  logic          busy_r, busy_s;
  logic          err_r, err_s;
  logic          arr_push_r, arr_push_s;
  logic          arr_pop_r, arr_pop_s;
  logic          arr_drop_r, arr_drop_s;
  logic [IW-1:0] arr_id_r, arr_id_s;
  logic [PW-1:0] arr_prio_r, arr_prio_s;
  logic [IW-1:0] arr_drop_id_r, arr_drop_id_s;
  logic          push_ack_r, push_ack_s;
  logic          pop_ack_r, pop_ack_s;
  logic          drop_ack_r, drop_ack_s;
  logic          ok_r, ok_s;
  logic [IW-1:0] pop_id_r, pop_id_s;
  logic [PW-1:0] pop_prio_r, pop_prio_s;
  logic          vld_s;
  logic          go_resp_s;
  logic          resp_ok_s;

  // Next-state, command, response and occupancy decode
  always_comb begin
    state_s       = state_r;
    op_s          = op_r;
    timer_s       = timer_r;
    count_s       = count_r;
    err_s         = err_r;
    arr_push_s    = 1'b0;
    arr_pop_s     = 1'b0;
    arr_drop_s    = 1'b0;
    arr_id_s      = arr_id_r;
    arr_prio_s    = arr_prio_r;
    arr_drop_id_s = arr_drop_id_r;
    push_ack_s    = 1'b0;
    pop_ack_s     = 1'b0;
    drop_ack_s    = 1'b0;
    ok_s          = 1'b0;
    pop_id_s      = pop_id_r;
    pop_prio_s    = pop_prio_r;
    vld_s         = 1'b0;
    go_resp_s     = 1'b0;
    resp_ok_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.pop_req_i) begin
          op_s = OP_POP;
          if (empty_r) begin
            go_resp_s = 1'b1;
          end else begin
            state_s   = ST_CMD;
            arr_pop_s = 1'b1;
          end
        end else if (bus.drop_req_i) begin
          op_s = OP_DROP;
          if (bus.drop_id_i == {IW{1'b0}}) begin
            go_resp_s = 1'b1;
          end else begin
            state_s       = ST_CMD;
            arr_drop_s    = 1'b1;
            arr_drop_id_s = bus.drop_id_i;
          end
        end else if (bus.push_req_i) begin
          op_s = OP_PUSH;
          if (full_r || (bus.push_id_i == {IW{1'b0}})) begin
            go_resp_s = 1'b1;
          end else begin
            state_s    = ST_CMD;
            arr_push_s = 1'b1;
            arr_id_s   = bus.push_id_i;
            arr_prio_s = bus.push_prio_i;
          end
        end else begin
          op_s = OP_NONE;
        end
      end
      ST_CMD: begin
        state_s = ST_WAIT;
        timer_s = {TW{1'b0}};
      end
      ST_WAIT: begin
        case (op_r)
          OP_PUSH: vld_s = bus.arr_push_vld_i;
          OP_POP:  vld_s = bus.arr_pop_vld_i;
          OP_DROP: vld_s = bus.arr_drop_vld_i;
          default: vld_s = 1'b0;
        endcase
        if (vld_s) begin
          go_resp_s = 1'b1;
          if (op_r == OP_DROP) begin
            resp_ok_s = bus.arr_drop_hit_i;
          end else begin
            resp_ok_s = 1'b1;
          end
          if (op_r == OP_POP) begin
            pop_id_s   = bus.arr_id_i;
            pop_prio_s = bus.arr_prio_i;
          end else begin
            pop_id_s   = pop_id_r;
            pop_prio_s = pop_prio_r;
          end
        end else if (timer_r == TW'(TMO - 1)) begin
          go_resp_s = 1'b1;
          err_s     = 1'b1;
        end else begin
          timer_s = timer_r + TW'(1);
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        op_s    = OP_NONE;
      end
      default: begin
        state_s = ST_IDLE;
        op_s    = OP_NONE;
      end
    endcase

    // Rejections, completions and timeouts all funnel through RESP with one ack
    if (go_resp_s) begin
      state_s = ST_RESP;
      ok_s    = resp_ok_s;
      case (op_s)
        OP_PUSH: begin
          push_ack_s = 1'b1;
          if (resp_ok_s) count_s = count_r + CW'(1);
          else           count_s = count_r;
        end
        OP_POP: begin
          pop_ack_s = 1'b1;
          if (resp_ok_s) count_s = count_r - CW'(1);
          else           count_s = count_r;
        end
        OP_DROP: begin
          drop_ack_s = 1'b1;
          if (resp_ok_s) count_s = count_r - CW'(1);
          else           count_s = count_r;
        end
        default: ok_s = 1'b0;
      endcase
    end else begin
      ok_s = 1'b0;
    end
  end

  assign full_s  = (count_s == CW'(DEPTH));
  assign empty_s = (count_s == {CW{1'b0}});
  assign busy_s  = (state_s != ST_IDLE);

  // FSM state, latched operation and WAIT timer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      op_r    <= OP_NONE;
      timer_r <= {TW{1'b0}};
    end else begin
      state_r <= state_s;
      op_r    <= op_s;
      timer_r <= timer_s;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_r       <= {CW{1'b0}};
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      busy_r        <= 1'b0;
      err_r         <= 1'b0;
      arr_push_r    <= 1'b0;
      arr_pop_r     <= 1'b0;
      arr_drop_r    <= 1'b0;
      arr_id_r      <= {IW{1'b0}};
      arr_prio_r    <= {PW{1'b0}};
      arr_drop_id_r <= {IW{1'b0}};
      push_ack_r    <= 1'b0;
      pop_ack_r     <= 1'b0;
      drop_ack_r    <= 1'b0;
      ok_r          <= 1'b0;
      pop_id_r      <= {IW{1'b0}};
      pop_prio_r    <= {PW{1'b0}};
    end else begin
      count_r       <= count_s;
      full_r        <= full_s;
      empty_r       <= empty_s;
      busy_r        <= busy_s;
      err_r         <= err_s;
      arr_push_r    <= arr_push_s;
      arr_pop_r     <= arr_pop_s;
      arr_drop_r    <= arr_drop_s;
      arr_id_r      <= arr_id_s;
      arr_prio_r    <= arr_prio_s;
      arr_drop_id_r <= arr_drop_id_s;
      push_ack_r    <= push_ack_s;
      pop_ack_r     <= pop_ack_s;
      drop_ack_r    <= drop_ack_s;
      ok_r          <= ok_s;
      pop_id_r      <= pop_id_s;
      pop_prio_r    <= pop_prio_s;
    end
  end

  assign bus.count_o       = count_r;
  assign bus.full_o        = full_r;
  assign bus.empty_o       = empty_r;
  assign bus.busy_o        = busy_r;
  assign bus.err_o         = err_r;
  assign bus.arr_push_o    = arr_push_r;
  assign bus.arr_pop_o     = arr_pop_r;
  assign bus.arr_drop_o    = arr_drop_r;
  assign bus.arr_id_o      = arr_id_r;
  assign bus.arr_prio_o    = arr_prio_r;
  assign bus.arr_drop_id_o = arr_drop_id_r;
  assign bus.push_ack_o    = push_ack_r;
  assign bus.pop_ack_o     = pop_ack_r;
  assign bus.drop_ack_o    = drop_ack_r;
  assign bus.ok_o          = ok_r;
  assign bus.pop_id_o      = pop_id_r;
  assign bus.pop_prio_o    = pop_prio_r;
endmodule

// File: tb/tb_pq_array_ctrl.sv
// Bench for pq_array_ctrl: a queue-based array model answers head-cell commands
// while a transaction-level model predicts ack timing, ok, occupancy and pop data.
module tb_pq_array_ctrl;
  localparam int IW       = 4;
  localparam int PW       = 8;
  localparam int DEPTH    = 8;
  localparam int TMO      = 16;
  localparam int OPC_PUSH = 1;
  localparam int OPC_POP  = 2;
  localparam int OPC_DROP = 3;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  pq_array_ctrl_if #(.IW(IW), .PW(PW), .DEPTH(DEPTH)) bus ();

  pq_array_ctrl #(.IW(IW), .PW(PW), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Array contents as seen by the array model
  logic [IW-1:0] arr_ids[$];
  logic [PW-1:0] arr_prs[$];
  int            lat     = 2;
  bit            no_resp = 1'b0;
  int            cd      = 0;
  int            pend_op = 0;
  logic [IW-1:0] pend_id = '0;
  logic [PW-1:0] pend_prio = '0;

  // Controller-level expectations
  int            exp_count = 0;
  bit            exp_err   = 1'b0;
  logic [IW-1:0] last_pid  = '0;
  logic [PW-1:0] last_pprio = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int head_idx();
    int h = 0;
    for (int i = 1; i < arr_prs.size(); i++)
      if (arr_prs[i] > arr_prs[h]) h = i;
    return h;
  endfunction

  function automatic int find_id(input logic [IW-1:0] id);
    for (int i = 0; i < arr_ids.size(); i++)
      if (arr_ids[i] == id) return i;
    return -1;
  endfunction

  task automatic arr_respond();
    int k;
    case (pend_op)
      OPC_PUSH: begin
        arr_ids.push_back(pend_id);
        arr_prs.push_back(pend_prio);
        bus.arr_push_vld_i = 1'b1;
      end
      OPC_POP: begin
        if (arr_ids.size() > 0) begin
          k = head_idx();
          bus.arr_id_i   = arr_ids[k];
          bus.arr_prio_i = arr_prs[k];
          arr_ids.delete(k);
          arr_prs.delete(k);
        end else begin
          bus.arr_id_i   = '0;
          bus.arr_prio_i = '0;
        end
        bus.arr_pop_vld_i = 1'b1;
      end
      OPC_DROP: begin
        k = find_id(pend_id);
        bus.arr_drop_hit_i = (k >= 0);
        if (k >= 0) begin
          arr_ids.delete(k);
          arr_prs.delete(k);
        end
        bus.arr_drop_vld_i = 1'b1;
      end
      default: ;
    endcase
  endtask

  // One clock: advance to the falling edge and let the array model react
  task automatic step();
    @(negedge clk_i);
    bus.arr_push_vld_i = 1'b0;
    bus.arr_pop_vld_i  = 1'b0;
    bus.arr_drop_vld_i = 1'b0;
    bus.arr_drop_hit_i = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) arr_respond();
    end
    if (bus.arr_push_o || bus.arr_pop_o || bus.arr_drop_o) begin
      pend_op   = bus.arr_push_o ? OPC_PUSH : (bus.arr_pop_o ? OPC_POP : OPC_DROP);
      pend_id   = bus.arr_push_o ? bus.arr_id_o : bus.arr_drop_id_o;
      pend_prio = bus.arr_prio_o;
      cd        = no_resp ? 0 : lat;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acks"},  {bus.push_ack_o, bus.pop_ack_o, bus.drop_ack_o, bus.ok_o}, 4'b0000);
    chk({tag, "_cmds"},  {bus.arr_push_o, bus.arr_pop_o, bus.arr_drop_o}, 3'b000);
    chk({tag, "_count"}, bus.count_o, 0);
    chk({tag, "_full"},  bus.full_o, 0);
    chk({tag, "_empty"}, bus.empty_o, 1);
    chk({tag, "_busy"},  bus.busy_o, 0);
    chk({tag, "_err"},   bus.err_o, 0);
    chk({tag, "_popd"},  {bus.pop_id_o, bus.pop_prio_o}, 0);
    chk({tag, "_opnd"},  {bus.arr_id_o, bus.arr_prio_o, bus.arr_drop_id_o}, 0);
  endtask

  task automatic clear_model();
    arr_ids.delete();
    arr_prs.delete();
    cd         = 0;
    pend_op    = 0;
    exp_count  = 0;
    exp_err    = 1'b0;
    last_pid   = '0;
    last_pprio = '0;
    bus.push_req_i     = 1'b0;
    bus.pop_req_i      = 1'b0;
    bus.drop_req_i     = 1'b0;
    bus.arr_push_vld_i = 1'b0;
    bus.arr_pop_vld_i  = 1'b0;
    bus.arr_drop_vld_i = 1'b0;
    bus.arr_drop_hit_i = 1'b0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    clear_model();
    repeat (2) @(negedge clk_i);
    chk_reset_vals("rst");
    rst_ni = 1'b1;
    step();
  endtask

  // Raise any mix of requests in an IDLE cycle and check each ack against the model
  task automatic serve(input bit q_pop, input bit q_drop, input bit q_push,
                       input logic [IW-1:0] pid, input logic [PW-1:0] pprio,
                       input logic [IW-1:0] did);
    bit            pp, pd, pu, rej, eok, tmo, acked;
    int            op, n, cyc, k;
    logic [2:0]    ebit, ack;
    logic [IW-1:0] epid;
    logic [PW-1:0] epprio;
    pp = q_pop; pd = q_drop; pu = q_push;
    bus.pop_req_i   = pp;
    bus.drop_req_i  = pd;
    bus.drop_id_i   = did;
    bus.push_req_i  = pu;
    bus.push_id_i   = pid;
    bus.push_prio_i = pprio;
    while (pp || pd || pu) begin
      op     = pp ? OPC_POP : (pd ? OPC_DROP : OPC_PUSH);
      ebit   = (op == OPC_PUSH) ? 3'b100 : ((op == OPC_POP) ? 3'b010 : 3'b001);
      rej    = (op == OPC_POP)  ? (exp_count == 0) :
               (op == OPC_DROP) ? (did == '0) : ((exp_count == DEPTH) || (pid == '0));
      tmo    = !rej && no_resp;
      epid   = last_pid;
      epprio = last_pprio;
      if (rej || tmo) begin
        eok = 1'b0;
        n   = rej ? 1 : TMO + 2;
      end else begin
        n = lat + 2;
        if (op == OPC_DROP) begin
          eok = (find_id(did) >= 0);
        end else begin
          eok = 1'b1;
        end
        if (op == OPC_POP) begin
          k      = head_idx();
          epid   = arr_ids[k];
          epprio = arr_prs[k];
        end
      end
      cyc   = 0;
      acked = 1'b0;
      while (!acked && cyc < TMO + 8) begin
        step();
        cyc++;
        chk("cmd", {bus.arr_push_o, bus.arr_pop_o, bus.arr_drop_o},
            (cyc == 1 && !rej) ? ebit : 3'b000);
        if (cyc == 1 && !rej && op == OPC_PUSH) chk("arr_id", {bus.arr_id_o, bus.arr_prio_o}, {pid, pprio});
        if (cyc == 1 && !rej && op == OPC_DROP) chk("arr_drop_id", bus.arr_drop_id_o, did);
        chk("busy", bus.busy_o, 1);
        ack = {bus.push_ack_o, bus.pop_ack_o, bus.drop_ack_o};
        if (ack != 3'b000) begin
          acked = 1'b1;
          if (eok) exp_count = exp_count + ((op == OPC_PUSH) ? 1 : -1);
          if (tmo) exp_err = 1'b1;
          if (eok && op == OPC_POP) begin
            last_pid   = epid;
            last_pprio = epprio;
          end
          chk("ack_cycle", cyc, n);
          chk("ack_which", ack, ebit);
          chk("ok", bus.ok_o, eok);
          chk("count", bus.count_o, exp_count);
          chk("full", bus.full_o, exp_count == DEPTH);
          chk("empty", bus.empty_o, exp_count == 0);
          chk("err", bus.err_o, exp_err);
          chk("pop_data", {bus.pop_id_o, bus.pop_prio_o}, {last_pid, last_pprio});
        end
      end
      chk("ack_seen", acked, 1);
      case (op)
        OPC_POP:  begin pp = 1'b0; bus.pop_req_i  = 1'b0; end
        OPC_DROP: begin pd = 1'b0; bus.drop_req_i = 1'b0; end
        default:  begin pu = 1'b0; bus.push_req_i = 1'b0; end
      endcase
      step();
      chk("idle_busy", bus.busy_o, 0);
      chk("idle_quiet", {bus.push_ack_o, bus.pop_ack_o, bus.drop_ack_o,
                         bus.arr_push_o, bus.arr_pop_o, bus.arr_drop_o}, 6'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            a, b, c;
    logic [IW-1:0] rid, rdid;
    logic [PW-1:0] rpr;
    bus.push_id_i   = '0;
    bus.push_prio_i = '0;
    bus.drop_id_i   = '0;
    bus.arr_id_i    = '0;
    bus.arr_prio_i  = '0;
    clear_model();

    apply_reset();

    // First push: command in cycle 1, vld in cycle 3, ack in cycle 4
    lat = 2;
    serve(1'b0, 1'b0, 1'b1, 4'd3, 8'd5, 4'd0);

    // Simultaneous pop/drop/push with two entries present
    serve(1'b0, 1'b0, 1'b1, 4'd4, 8'd9, 4'd0);
    lat = 1;
    serve(1'b1, 1'b1, 1'b1, 4'd6, 8'd2, 4'd3);

    // Fill to DEPTH, then a rejected push
    for (int i = 1; i <= 7; i++) serve(1'b0, 1'b0, 1'b1, IW'(i), PW'(i * 3), 4'd0);
    serve(1'b0, 1'b0, 1'b1, 4'd9, 8'd1, 4'd0);

    // Rejections on an empty queue
    apply_reset();
    serve(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);
    serve(1'b0, 1'b0, 1'b1, 4'd0, 8'd7, 4'd0);
    serve(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 4'd0);

    // Drop miss, then drop hit
    lat = 3;
    serve(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 4'd7);
    serve(1'b0, 1'b0, 1'b1, 4'd7, 8'd1, 4'd0);
    serve(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 4'd7);

    // Pop timeout sets a sticky error
    serve(1'b0, 1'b0, 1'b1, 4'd2, 8'd8, 4'd0);
    no_resp = 1'b1;
    serve(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 4'd0);
    no_resp = 1'b0;
    serve(1'b0, 1'b0, 1'b1, 4'd5, 8'd3, 4'd0);

    // Asynchronous reset in the middle of WAIT
    no_resp = 1'b1;
    bus.pop_req_i = 1'b1;
    repeat (5) step();
    chk("mid_busy", bus.busy_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals("midrst");
    clear_model();
    repeat (3) begin
      step();
      chk("midrst_noack", {bus.push_ack_o, bus.pop_ack_o, bus.drop_ack_o}, 3'b000);
    end
    rst_ni  = 1'b1;
    no_resp = 1'b0;
    step();

    // Randomized request mixes against the model
    for (int it = 0; it < 60; it++) begin
      a = ($urandom_range(0, 2) == 0);
      b = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 2) != 0);
      if (!(a || b || c)) c = 1'b1;
      rid = IW'($urandom_range(0, 15));
      rpr = PW'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1 && arr_ids.size() > 0)
        rdid = arr_ids[$urandom_range(0, arr_ids.size() - 1)];
      else
        rdid = IW'($urandom_range(0, 15));
      lat     = $urandom_range(1, 4);
      no_resp = ($urandom_range(0, 15) == 0);
      serve(a, b, c, rid, rpr, rdid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pq_array_ctrl.md
Name: pq_array_ctrl

Overview:
- Front-end sequencer for the systolic priority-queue cell array.
- Accepts push, pop and drop requests from client logic and arbitrates them, fixed priority pop > drop > push.
- Issues exactly one command at a time to the head cell, waits for the array's valid strobe, then returns a one-cycle acknowledge.
- Tracks occupancy and reports full/empty, so clients never see cell-level timing.

Parameters:
- IW, 4, entry ID width; ID 0 is reserved as the empty-cell marker.
- PW, 8, priority width.
- DEPTH, 8, number of cells in the array (max entries).
- TMO, 16, cycles allowed in WAIT before timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- push_req_i  in  1  push request, held until ack
- push_id_i  in  IW  ID to insert
- push_prio_i  in  PW  priority to insert
- pop_req_i  in  1  pop request, held until ack
- drop_req_i  in  1  drop request, held until ack
- drop_id_i  in  IW  ID to remove
- push_ack_o  out  1  one-cycle push completion
- pop_ack_o  out  1  one-cycle pop completion
- drop_ack_o  out  1  one-cycle drop completion
- ok_o  out  1  qualifies any ack: 1 = performed, 0 = rejected or timed out
- pop_id_o  out  IW  popped ID, valid with pop_ack_o
- pop_prio_o  out  PW  popped priority, valid with pop_ack_o
- arr_push_o  out  1  push command to head cell
- arr_pop_o  out  1  pop command to head cell
- arr_drop_o  out  1  drop command to head cell
- arr_id_o  out  IW  ID driven with push
- arr_prio_o  out  PW  priority driven with push
- arr_drop_id_o  out  IW  ID driven with drop
- arr_push_vld_i  in  1  array push complete
- arr_pop_vld_i  in  1  array pop data valid
- arr_drop_vld_i  in  1  array drop complete
- arr_drop_hit_i  in  1  entry found; qualifies arr_drop_vld_i
- arr_id_i  in  IW  head-cell ID
- arr_prio_i  in  PW  head-cell priority
- count_o  out  $clog2(DEPTH+1)  occupancy
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset is asynchronous, active-low, on rst_ni; clock is clk_i. All outputs are registered.
- Reset values: all outputs 0 except empty_o = 1. State = IDLE, op = none, timer = 0.
- Reset mid-operation aborts the command; no ack is generated. The array is reset by the same rst_ni.
- States: IDLE, CMD, WAIT, RESP.
- IDLE:
  - Pick the highest-priority pending request and latch the op plus its operands.
  - Reject with no array access, going directly to RESP with ok = 0, when:
    - push and full_o;
    - push with push_id_i == 0;
    - pop and empty_o;
    - drop with drop_id_i == 0.
  - Otherwise go to CMD.
- CMD:
  - The matching arr_*_o is high for exactly this one cycle, with operands stable.
  - Then go to WAIT and clear the timer.
- WAIT:
  - On the matching arr_*_vld_i, go to RESP with ok = 1. The exception is drop: ok = arr_drop_hit_i.
  - For pop, latch arr_id_i and arr_prio_i in the same cycle into pop_id_o and pop_prio_o.
  - Non-matching vld inputs are ignored.
  - Timer increments each cycle. At TMO-1 without vld, go to RESP with ok = 0 and set err_o. err_o clears only on reset.
- RESP:
  - The matching ack is high for one cycle, with ok_o valid alongside it.
  - Count update in the same cycle:
    - push ok: +1;
    - pop ok: -1;
    - drop ok (hit): -1;
    - otherwise unchanged.
  - Next state is IDLE. A request still held is not re-arbitrated until the cycle after the ack. Clients must drop their request on ack.
- Latency:
  - Request sampled at edge 0, command issued in cycle 1.
  - Ack arrives 1 cycle after array vld.
  - Rejected requests ack in cycle 1.
- Simultaneous requests: pop wins, then drop, then push. Losers are served in later IDLE visits.
- Count never wraps. An ok push at DEPTH or ok pop at 0 cannot occur because of the rejection rules.
- pop_id_o and pop_prio_o hold their value until the next successful pop.

Test Plan:
- Reset, then push ID 3 prio 5 with an array model returning vld 2 cycles after the command → arr_push_o pulses in cycle 1, push_ack_o with ok = 1 in cycle 4, count_o = 1, empty_o = 0.
- Push, pop and drop asserted together, count = 2 → serviced in order pop, drop, push. Each ack is separated by at least CMD+WAIT+RESP, and only one arr_*_o is active at any time.
- 8 pushes, then a 9th push ID 9 → 9th acks in cycle 1 with ok = 0, no arr_push_o, full_o = 1, count_o stays 8.
- Pop when empty; push with ID 0 → immediate ack with ok = 0, no array command, count_o = 0.
- Drop ID 7 with the model returning arr_drop_vld_i and hit = 0 → drop_ack_o with ok = 0, count unchanged. Repeat with hit = 1 → ok = 1, count decrements.
- Model never returns vld for a pop → pop_ack_o with ok = 0 after TMO cycles in WAIT, err_o = 1 sticky. Assert rst_ni mid-WAIT on a later op → all outputs are at reset values immediately, with no ack.
